// File: rtl/operand_fetch.sv
// Fetches two source operands through one shared register-file port; writebacks always win the port.
// op_valid follows the accept cycle by 4 cycles (3 when rs1==rs2) plus one cycle per blocked read; held until op_ready.
module operand_fetch #(
   parameter int DATA_W  = 64,
   parameter int STALL_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [4:0]          req_rs1,
   input  logic [4:0]          req_rs2,
   output logic                op_valid,
   input  logic                op_ready,
   output logic [DATA_W-1:0]   op_a,
   output logic [DATA_W-1:0]   op_b,
   input  logic                wb_valid,
   output logic                wb_ready,
   input  logic [4:0]          wb_reg,
   input  logic [DATA_W-1:0]   wb_data,
   output logic [31:0]         rf_register_num,
   output logic                rf_read,
   output logic                rf_write,
   output logic [DATA_W-1:0]   rf_in,
   input  logic [DATA_W-1:0]   rf_out,
   output logic [STALL_W-1:0]  stall_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_A   = 3'd1,
      RD_B   = 3'd2,
      WAIT_B = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   state_t     state;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       same_reg;
   logic       read_slot;

   assign same_reg  = (rs1 == rs2);
   assign wb_ready  = ~reset;
   assign req_ready = ~reset & (state == IDLE);
   assign rf_write  = wb_valid & wb_ready;
   assign read_slot = ~reset & ((state == RD_A) | (state == RD_B));
   // A pending writeback takes the port; the read is simply retried next cycle.
   assign rf_read   = read_slot & ~wb_valid;
   assign rf_in     = wb_data;

   always_comb begin
      rf_register_num = '0;
      if (rf_write)
         rf_register_num = {27'd0, wb_reg};
      else if (rf_read)
         rf_register_num = {27'd0, (state == RD_A) ? rs1 : rs2};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rs1       <= '0;
         rs2       <= '0;
         op_valid  <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         stall_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rs1   <= req_rs1;
                  rs2   <= req_rs2;
                  state <= RD_A;
               end
            end
            RD_A: begin
               if (wb_valid) begin
                  if (stall_cnt != STALL_MAX)
                     stall_cnt <= stall_cnt + STALL_W'(1);
               end else begin
                  state <= same_reg ? WAIT_B : RD_B;
               end
            end
            RD_B: begin
               if (wb_valid) begin
                  if (stall_cnt != STALL_MAX)
                     stall_cnt <= stall_cnt + STALL_W'(1);
               end else begin
                  // rf_out still holds the rs1 read; stalls never disturb it.
                  op_a  <= rf_out;
                  state <= WAIT_B;
               end
            end
            WAIT_B: begin
               op_b <= rf_out;
               if (same_reg)
                  op_a <= rf_out;
               op_valid <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               if (op_ready) begin
                  op_valid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized bench for operand_fetch with an external register-file fixture and an architectural model.
module tb_operand_fetch;
   localparam int DATA_W  = 64;
   localparam int STALL_W = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic                req_valid;
   logic                req_ready;
   logic [4:0]          req_rs1;
   logic [4:0]          req_rs2;
   logic                op_valid;
   logic                op_ready;
   logic [DATA_W-1:0]   op_a;
   logic [DATA_W-1:0]   op_b;
   logic                wb_valid;
   logic                wb_ready;
   logic [4:0]          wb_reg;
   logic [DATA_W-1:0]   wb_data;
   logic [31:0]         rf_register_num;
   logic                rf_read;
   logic                rf_write;
   logic [DATA_W-1:0]   rf_in;
   logic [DATA_W-1:0]   rf_out = '0;
   logic [STALL_W-1:0]  stall_cnt;

   logic [DATA_W-1:0]   mem  [32] = '{default: '0};
   logic [DATA_W-1:0]   arch [32] = '{default: '0};
   logic [STALL_W-1:0]  exp_stall = '0;
   int                  total = 0;
   int                  bad   = 0;

   always #5 clk = ~clk;

   operand_fetch #(.DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
      .rf_register_num(rf_register_num), .rf_read(rf_read), .rf_write(rf_write),
      .rf_in(rf_in), .rf_out(rf_out), .stall_cnt(stall_cnt)
   );

   // Register file: single port, registered read data that holds until the next read.
   always @(posedge clk) begin
      if (rf_write) mem[rf_register_num[4:0]] <= rf_in;
      if (rf_read)  rf_out <= mem[rf_register_num[4:0]];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_wb(input logic v, input logic [4:0] r, input logic [DATA_W-1:0] d);
      wb_valid = v;
      wb_reg   = r;
      wb_data  = d;
      if (v) arch[r] = d;
   endtask

   task automatic wr(input logic [4:0] r, input logic [DATA_W-1:0] d);
      drive_wb(1'b1, r, d);
      @(posedge clk);
      @(negedge clk);
      drive_wb(1'b0, 5'd0, '0);
   endtask

   // Called at a negedge with the DUT idle. force_n: cycles after accept that carry a forced writeback.
   // rst_cyc: cycle after accept in which reset is pulsed (-1 for none).
   task automatic fetch(input logic [4:0] a, input logic [4:0] b, input int force_n,
                        input logic [4:0] force_reg, input logic [DATA_W-1:0] force_dat,
                        input bit rnd, input int hold, input int rst_cyc);
      int nreads, reads_done, stalls, c, rd_seen, viol;
      logic [DATA_W-1:0] ea, eb;
      bit got;
      nreads = (a == b) ? 1 : 2;
      reads_done = 0; stalls = 0; c = 0; rd_seen = 0; viol = 0; got = 0;
      ea = '0; eb = '0;
      req_valid = 1'b1; req_rs1 = a; req_rs2 = b;
      drive_wb(1'b0, 5'd0, '0);
      #1 check("req_ready_idle", 64'(req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      while (c < force_n + 40) begin
         c++;
         if (op_valid) begin
            got = 1;
            break;
         end
         if (c == rst_cyc) begin
            drive_wb(1'b0, 5'd0, '0);
            #2 reset = 1'b1;
            #1;
            check("rst_ctrl", 64'({op_valid, req_ready, wb_ready, rf_read, rf_write}), 64'd0);
            check("rst_ops", op_a | op_b, 64'd0);
            check("rst_stall", 64'(stall_cnt), 64'd0);
            check("rst_regnum", 64'(rf_register_num), 64'd0);
            exp_stall = '0;
            @(negedge clk);
            reset = 1'b0;
            #1 check("rst_release_ready", 64'(req_ready), 64'd1);
            @(posedge clk);
            @(negedge clk);
            check("rst_no_pulse", 64'({op_valid, req_ready}), 64'b01);
            return;
         end
         if (c <= force_n)
            drive_wb(1'b1, force_reg, force_dat);
         else if (rnd && $urandom_range(0, 2) == 0)
            drive_wb(1'b1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
         else
            drive_wb(1'b0, 5'd0, '0);
         #1;
         if ((rf_read && rf_write) || rf_register_num[31:5] != 27'd0 || rf_write != wb_valid) viol++;
         rd_seen += int'(rf_read);
         // Each cycle of the read phase either loses the port to a writeback or performs the next read.
         if (reads_done < nreads) begin
            if (wb_valid) begin
               stalls++;
               if (exp_stall != '1) exp_stall++;
            end else begin
               if (reads_done == 0) begin
                  ea = arch[a];
                  if (a == b) eb = arch[a];
               end else begin
                  eb = arch[b];
               end
               reads_done++;
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      if (!got) begin
         check("op_valid_timeout", 64'd0, 64'd1);
         drive_wb(1'b0, 5'd0, '0);
         return;
      end
      // Latency counted in cycles from the accept cycle to the first cycle showing op_valid.
      check("latency", 64'(c), 64'(2 + nreads + stalls));
      check("op_a", op_a, ea);
      check("op_b", op_b, eb);
      check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      check("req_ready_busy", 64'(req_ready), 64'd0);
      for (int h = 0; h < hold; h++) begin
         op_ready = 1'b0;
         if ($urandom_range(0, 3) != 0)
            drive_wb(1'b1, a, {$urandom, $urandom});
         else
            drive_wb(1'b0, 5'd0, '0);
         #1;
         if ((rf_read && rf_write) || rf_register_num[31:5] != 27'd0 || rf_write != wb_valid) viol++;
         rd_seen += int'(rf_read);
         @(posedge clk);
         @(negedge clk);
      end
      if (hold > 0) begin
         check("hold_valid", 64'({op_valid, req_ready}), 64'b10);
         check("hold_a", op_a, ea);
         check("hold_b", op_b, eb);
      end
      drive_wb(1'b0, 5'd0, '0);
      op_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op_ready = 1'b0;
      check("handoff", 64'({op_valid, req_ready}), 64'b01);
      check("rf_read_pulses", 64'(rd_seen), 64'(nreads));
      check("port_rules", 64'(viol), 64'd0);
   endtask

   initial begin
      logic [4:0] a, b;
      reset = 1'b1;
      req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
      op_ready = 1'b0;
      wb_valid = 1'b1; wb_reg = 5'd4; wb_data = '1;
      repeat (2) @(negedge clk);
      check("reset_ctrl", 64'({op_valid, req_ready, wb_ready, rf_read, rf_write}), 64'd0);
      check("reset_ops", op_a | op_b, 64'd0);
      check("reset_stall", 64'(stall_cnt), 64'd0);
      drive_wb(1'b0, 5'd0, '0);
      reset = 1'b0;
      #1;
      check("post_reset_ready", 64'({req_ready, wb_ready}), 64'b11);
      check("idle_port", 64'({rf_register_num, rf_read, rf_write}), 64'd0);
      @(negedge clk);

      wr(5'd3, 64'hAAAA);
      wr(5'd7, 64'h5555);
      wr(5'd9, 64'h1234);
      fetch(5'd3, 5'd7, 0, 5'd0, '0, 1'b0, 0, -1);
      fetch(5'd9, 5'd9, 0, 5'd0, '0, 1'b0, 0, -1);
      fetch(5'd3, 5'd7, 2, 5'd7, 64'h77, 1'b0, 0, -1);
      fetch(5'd3, 5'd7, 0, 5'd0, '0, 1'b0, 5, -1);
      fetch(5'd0, 5'd9, 0, 5'd0, '0, 1'b0, 0, -1);
      wr(5'd5, 64'hC0FFEE);
      fetch(5'd5, 5'd6, 0, 5'd0, '0, 1'b0, 0, 2);
      fetch(5'd5, 5'd6, 0, 5'd0, '0, 1'b0, 0, -1);

      repeat (30) begin
         a = 5'($urandom_range(0, 31));
         b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
         fetch(a, b, 0, 5'd0, '0, 1'b1, $urandom_range(0, 3), -1);
      end

      fetch(5'd1, 5'd2, (1 << STALL_W) + 3, 5'd20, 64'hDEAD, 1'b0, 0, -1);
      check("stall_saturated", 64'(stall_cnt), 64'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
